// File: rtl/fetch_queue.sv
// Circular instruction buffer between ICache data return and decode; holds {pc, instr, ecode}.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards an arriving entry straight to decode when empty.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int SKID  = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic [7:0]               in_ecode,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [7:0]               out_ecode,
  output logic                     stall_full_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - SKID);

  typedef struct packed {
    logic [7:0]  ecode;
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               head_valid;
  logic               bypass;
  logic               pop_mem;
  logic               push_ok;
  logic               push_mem;
  logic               drop;
  entry_t             in_entry;
  entry_t             head_entry;

  assign in_entry   = '{ecode: in_ecode, instr: in_instr, pc: in_pc};
  assign head_entry = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = !head_valid && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign pop_mem  = head_valid && out_ready && !flush;
  assign push_ok  = in_valid && !flush && ((count_q < FULL_CNT) || pop_mem);
  // A bypassed entry that decode takes immediately never touches storage.
  assign push_mem = push_ok && !(bypass && out_ready);
  assign drop     = in_valid && (count_q == FULL_CNT) && !pop_mem && !flush;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || drop;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_mem) begin
        mem_d[wr_ptr_q] = in_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_mem) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_mem && !pop_mem) begin
        count_d = count_q + 1'b1;
      end else if (pop_mem && !push_mem) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage holds data only and is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    out_valid = head_valid || bypass;
    out_pc    = '0;
    out_instr = '0;
    out_ecode = '0;
    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
      out_ecode = in_ecode;
    end else if (head_valid) begin
      out_pc    = head_entry.pc;
      out_instr = head_entry.instr;
      out_ecode = head_entry.ecode;
    end
  end

  assign stall_full_instr = (count_q >= STALL_CNT);
  assign count            = count_q;
  assign overflow         = overflow_q;

endmodule
